lsu_mem_ctrl: RTL

// - MEM-stage load/store unit. Consumes the flopped EX->MEM controls (mem read/write, func3) plus address and store data.
// - Runs one request/grant/rvalid transaction per access on the data bus (DMEM or memory-mapped GEMM accelerator).
// - Stalls the pipeline until the access completes, then returns aligned, sign/zero-extended load data to writeback.

---
 rtl/lsu_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl -- MEM-stage load/store unit.
//
// Takes the flopped EX->MEM memory controls, runs one request/grant/rvalid
// transaction on the data bus (DMEM or the memory-mapped GEMM accelerator),
// stalls IF..MEM while the access is in flight and returns the aligned,
// sign/zero-extended load result to writeback.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses instead of silently aligning them down.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   mem_read_i        load in MEM stage
//   mem_write_i       store in MEM stage (wins over mem_read_i)
//   func3_i           RV32I access size / sign encoding
//   addr_i, wdata_i   effective address, store data (rs2)
//   flush_i           kill the instruction currently in MEM
//   bus_req_o ..      bus request channel: req, we, word address, lane-
//   bus_be_o          replicated write data, byte enables
//   bus_gnt_i         request accepted
//   bus_rvalid_i      read data valid, with bus_rdata_i
//   stall_o           freeze IF..MEM
//   load_data_o       extended load result, held until the next load
//   load_valid_o      one-cycle pulse when load_data_o is updated
//   misalign_o        one-cycle misaligned-access pulse (trap build only)
//   misalign_addr_o   faulting address while misalign_o is high
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Stores only know SB/SH/SW; loads additionally have LBU/LHU in func3[2].
  // Every unlisted encoding behaves as a word access.
  function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_W;
    if (we) begin
      if (f3 == 3'b000)      sz = SZ_B;
      else if (f3 == 3'b001) sz = SZ_H;
    end else begin
      if (f3[1:0] == 2'b00)      sz = SZ_B;
      else if (f3[1:0] == 2'b01) sz = SZ_H;
    end
    return sz;
  endfunction

  // Byte lane of the access; halfwords drop addr[0], words drop addr[1:0].
  function automatic logic [1:0] lane_offset(input logic [1:0] sz, input logic [1:0] a);
    logic [1:0] off;
    case (sz)
      SZ_B:    off = a;
      SZ_H:    off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic              kill_q, kill_d;      // load flushed after grant: drop its data
  logic              mis_q, mis_d;        // current access trapped as misaligned
  logic [DATA_W-1:0] load_data_q, load_data_d;

  // ---------------------------------------------------------------------------
  // Incoming request decode (used only when latching in IDLE)
  // ---------------------------------------------------------------------------
  logic              access;
  logic [1:0]        size_in;
  logic [1:0]        off_in;
  logic [3:0]        be_in;
  logic [DATA_W-1:0] wdata_in;
  logic              misalign_in;

  assign access  = mem_read_i | mem_write_i;
  assign size_in = access_size(mem_write_i, func3_i);
  assign off_in  = lane_offset(size_in, addr_i[1:0]);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wdata_i;
    case (size_in)
      SZ_B: begin
        be_in    = 4'b0001 << off_in;
        wdata_in = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_in    = 4'b0011 << off_in;
        wdata_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_in = ((size_in == SZ_H) && addr_i[0]) ||
                       ((size_in == SZ_W) && (addr_i[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load data alignment and extension, from the latched request
  // ---------------------------------------------------------------------------
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              sign_q;
  logic [DATA_W-1:0] rdata_sh;
  logic [DATA_W-1:0] rdata_ext;

  assign size_q   = access_size(we_q, func3_q);
  assign off_q    = lane_offset(size_q, addr_q[1:0]);
  assign sign_q   = ~func3_q[2];
  assign rdata_sh = bus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    rdata_ext = rdata_sh;
    case (size_q)
      SZ_B:    rdata_ext = {{24{sign_q & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H:    rdata_ext = {{16{sign_q & rdata_sh[15]}}, rdata_sh[15:0]};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    kill_d      = kill_q;
    mis_d       = mis_q;
    load_data_d = load_data_q;

    case (state_q)
      S_IDLE: begin
        if (access && !flush_i) begin
          we_d    = mem_write_i;
          addr_d  = addr_i;
          be_d    = be_in;
          wdata_d = wdata_in;
          func3_d = func3_i;
          kill_d  = 1'b0;
          mis_d   = misalign_in;
          // A trapped access never touches the bus.
          state_d = misalign_in ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        if (bus_gnt_i) begin
          // Once granted the bus cannot be aborted; a flush only discards data.
          kill_d = flush_i;
          if (we_q) begin
            state_d = S_DONE;
          end else if (bus_rvalid_i) begin
            if (!flush_i) load_data_d = rdata_ext;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_R;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_R: begin
        if (flush_i) kill_d = 1'b1;
        if (bus_rvalid_i) begin
          if (!(kill_q || flush_i)) load_data_d = rdata_ext;
          state_d = S_DONE;
        end
      end

      // The pipeline advances at the end of DONE, so IDLE sees the next
      // instruction and the same access is never replayed.
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: all state is reset here (there is no memory array), which also zeroes
  // every registered output and drops bus_req_o on the edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      kill_q      <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      func3_q     <= func3_d;
      kill_q      <= kill_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;

  // IDLE stalls combinationally the cycle the access shows up; DONE releases.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:   stall_o = access & ~flush_i;
      S_REQ:    stall_o = 1'b1;
      S_WAIT_R: stall_o = 1'b1;
      default:  stall_o = 1'b0;
    endcase
    if (reset) stall_o = 1'b0;
  end

  assign load_data_o  = load_data_q;
  assign load_valid_o = (state_q == S_DONE) & ~we_q & ~kill_q & ~mis_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o      = (state_q == S_DONE) & mis_q;
  assign misalign_addr_o = misalign_o ? addr_q : '0;
`else
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

endmodule
